// File: rtl/alu_multiciclo_if.sv
// Handshake/operand bundle for alu_multiciclo.
//   master : drives iStart, iALU_Sel, iA, iB; observes the result side
//   slave  : the ALU; drives oBusy, oDone, oRESALU, oBanderas, oErr
interface alu_multiciclo_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [4:0]       iALU_Sel;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oRESALU;
  logic [4:0]       oBanderas;
  logic             oErr;

  modport master (
    output iStart, iALU_Sel, iA, iB,
    input  oBusy, oDone, oRESALU, oBanderas, oErr
  );

  modport slave (
    input  iStart, iALU_Sel, iA, iB,
    output oBusy, oDone, oRESALU, oBanderas, oErr
  );
endinterface

// File: rtl/alu_multiciclo.sv
// Multi-cycle handshaked ALU. One operation per accepted iStart; logic,
// arithmetic and shift ops finish after FIN, MUL/DIV/MOD iterate WIDTH cycles
// through a shared shift register pair (hi, lo) before FIN.
// Ports:
//   iClk      clock, rising edge
//   iRst      synchronous active-high reset
//   bus       alu_multiciclo_if.slave: iStart/iALU_Sel/iA/iB in,
//             oBusy/oDone/oRESALU/oBanderas{P,V,C,S,Z}/oErr out (all registered)
//
// state | meaning
// IDLE  | waiting for iStart; operands captured on accept
// ITER  | one multiply/divide step per cycle, counter counts down to 0
// FIN   | result/flags/error loaded, oDone pulsed, back to IDLE
module alu_multiciclo #(
  parameter int WIDTH = 8
) (
  input logic iClk,
  input logic iRst,
  alu_multiciclo_if.slave bus
);
  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [SHW-1:0]   AMT_W   = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic [4:0] OP_MUL = 5'b00000;
  localparam logic [4:0] OP_DIV = 5'b00001;
  localparam logic [4:0] OP_INC = 5'b00010;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b00110;
  localparam logic [4:0] OP_XOR = 5'b00111;
  localparam logic [4:0] OP_NEG = 5'b01000;
  localparam logic [4:0] OP_ASL = 5'b01001;
  localparam logic [4:0] OP_ASR = 5'b01010;
  localparam logic [4:0] OP_LSL = 5'b01011;
  localparam logic [4:0] OP_LSR = 5'b01100;
  localparam logic [4:0] OP_ROL = 5'b01101;
  localparam logic [4:0] OP_ROR = 5'b01110;
  localparam logic [4:0] OP_ADD = 5'b01111;
  localparam logic [4:0] OP_SUB = 5'b10000;
  localparam logic [4:0] OP_MOD = 5'b10001;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t           state;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] hi, lo, hi_nxt, lo_nxt;
  logic [CW-1:0]    cnt;
  logic             busy, done, err;
  logic [WIDTH-1:0] res;
  logic [4:0]       flags;

  assign bus.oBusy     = busy;
  assign bus.oDone     = done;
  assign bus.oRESALU   = res;
  assign bus.oBanderas = flags;
  assign bus.oErr      = err;

  // Iteration step. MUL: hi accumulates, lo holds the multiplier and receives
  // the low product bits as {hi,lo} shifts right. DIV/MOD: restoring divide,
  // hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [WIDTH:0] mul_sum, div_tmp;
  logic           div_ge;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_tmp = {hi, lo[WIDTH-1]};
    div_ge  = div_tmp >= {1'b0, b_r};
    if (op_r == OP_MUL) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      // remainder < divisor, so the difference always fits in WIDTH bits
      hi_nxt = div_ge ? (div_tmp[WIDTH-1:0] - b_r) : div_tmp[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ge};
    end
  end

  // Result, carry, overflow and error for the operation held in op_r.
  logic [SHW-1:0]     amt;
  logic               amt_big;
  logic [2*WIDTH-1:0] shl;
  logic [WIDTH-1:0]   out_mask, out_bits;
  logic [WIDTH:0]     shr, sar, add_sum;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c, fin_v, fin_err, fin_legal, asl_v;

  always_comb begin
    amt      = b_r[SHW-1:0];
    amt_big  = amt > AMT_W;
    shl      = {{WIDTH{1'b0}}, a_r} << amt;
    // bits pushed past the MSB by a left shift of amt <= WIDTH
    out_mask = ~({WIDTH{1'b1}} << amt);
    out_bits = shl[2*WIDTH-1:WIDTH] & out_mask;
    asl_v    = shl[WIDTH-1] ? |(~out_bits & out_mask) : |out_bits;
    // one extra LSB catches the last bit shifted out to the right
    shr      = {a_r, 1'b0} >> amt;
    sar      = $signed({a_r, 1'b0}) >>> amt;
    add_sum  = {1'b0, a_r} + {1'b0, b_r};

    fin_res   = '0;
    fin_c     = 1'b0;
    fin_v     = 1'b0;
    fin_err   = 1'b0;
    fin_legal = 1'b1;
    case (op_r)
      OP_MUL: begin
        fin_res = lo;
        fin_c   = |hi;
        fin_v   = |hi;
      end
      OP_DIV: begin
        fin_res = (b_r == '0) ? '1 : lo;
        fin_err = (b_r == '0);
      end
      OP_MOD: begin
        fin_res = (b_r == '0) ? a_r : hi;
        fin_err = (b_r == '0);
      end
      OP_INC: begin
        fin_res = a_r + WIDTH'(1);
        fin_c   = &a_r;
        fin_v   = (a_r == SMAX);
      end
      OP_DEC: begin
        fin_res = a_r - WIDTH'(1);
        fin_c   = (a_r == '0);
        fin_v   = (a_r == SMIN);
      end
      OP_AND: fin_res = a_r & b_r;
      OP_OR:  fin_res = a_r | b_r;
      OP_NOT: fin_res = ~a_r;
      OP_XOR: fin_res = a_r ^ b_r;
      OP_NEG: begin
        fin_res = ~a_r + WIDTH'(1);
        fin_v   = (a_r == SMIN);
      end
      OP_ASL: begin
        fin_res = amt_big ? '0 : shl[WIDTH-1:0];
        fin_c   = amt_big ? 1'b0 : shl[WIDTH];
        fin_v   = amt_big ? |a_r : asl_v;
      end
      OP_LSL: begin
        fin_res = amt_big ? '0 : shl[WIDTH-1:0];
        fin_c   = amt_big ? 1'b0 : shl[WIDTH];
      end
      OP_LSR: begin
        fin_res = amt_big ? '0 : shr[WIDTH:1];
        fin_c   = amt_big ? 1'b0 : shr[0];
      end
      OP_ASR: begin
        fin_res = amt_big ? {WIDTH{a_r[WIDTH-1]}} : sar[WIDTH:1];
        fin_c   = amt_big ? a_r[WIDTH-1] : sar[0];
      end
      OP_ROL: begin
        fin_res = {a_r[WIDTH-2:0], a_r[WIDTH-1]};
        fin_c   = a_r[WIDTH-1];
      end
      OP_ROR: begin
        fin_res = {a_r[0], a_r[WIDTH-1:1]};
        fin_c   = a_r[0];
      end
      OP_ADD: begin
        fin_res = add_sum[WIDTH-1:0];
        fin_c   = add_sum[WIDTH];
        fin_v   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res = a_r - b_r;
        fin_c   = a_r < b_r;
        fin_v   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (fin_res[WIDTH-1] != a_r[WIDTH-1]);
      end
      default: begin
        fin_legal = 1'b0;
        fin_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      res   <= '0;
      flags <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            op_r <= bus.iALU_Sel;
            a_r  <= bus.iA;
            b_r  <= bus.iB;
            busy <= 1'b1;
            if (bus.iALU_Sel == OP_MUL || bus.iALU_Sel == OP_DIV ||
                bus.iALU_Sel == OP_MOD) begin
              state <= ITER;
              cnt   <= CW'(WIDTH - 1);
              hi    <= '0;
              lo    <= (bus.iALU_Sel == OP_MUL) ? bus.iB : bus.iA;
            end else begin
              state <= FIN;
            end
          end
        end
        ITER: begin
          hi <= hi_nxt;
          lo <= lo_nxt;
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - CW'(1);
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= fin_err;
          // illegal opcodes leave the previous result and flags in place
          if (fin_legal) begin
            res   <= fin_res;
            flags <= {~^fin_res, fin_v, fin_c, fin_res[WIDTH-1], fin_res == '0};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_multiciclo_if #(.WIDTH(8)) bus();
  alu_multiciclo #(.WIDTH(8)) dut (.iClk(clk), .iRst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] prev_res = 8'h00;
  logic [4:0] prev_fl  = 5'h00;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] fl;
    logic       err;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  task automatic model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r8, output logic [4:0] f, output logic e);
    int ua, ub, sa, sb, amt, t, r;
    logic c, v, legal;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    amt = ub % 16;
    c = 1'b0; v = 1'b0; e = 1'b0; legal = 1'b1; r = 0;
    case (op)
      5'd0: begin t = ua * ub; r = t % 256; c = (t > 255); v = c; end
      5'd1: begin if (ub == 0) begin r = 255; e = 1'b1; end else r = ua / ub; end
      5'd17: begin if (ub == 0) begin r = ua; e = 1'b1; end else r = ua % ub; end
      5'd2: begin r = (ua + 1) % 256; c = (ua == 255); v = (ua == 127); end
      5'd3: begin r = (ua + 255) % 256; c = (ua == 0); v = (ua == 128); end
      5'd4: r = ua & ub;
      5'd5: r = ua | ub;
      5'd6: r = 255 - ua;
      5'd7: r = ua ^ ub;
      5'd8: begin r = (256 - ua) % 256; v = (ua == 128); end
      5'd9, 5'd11: begin
        r = (ua << amt) % 256;
        c = (((ua << amt) >> 8) & 1) != 0;
        if (op == 5'd9)
          for (int k = 1; k <= amt; k++) begin
            int bitv;
            bitv = (8 - k >= 0) ? ((ua >> (8 - k)) & 1) : 0;
            if (bitv != ((r >> 7) & 1)) v = 1'b1;
          end
      end
      5'd10: begin
        r = (sa >>> amt) & 255;
        c = (amt == 0) ? 1'b0 : (((sa >>> (amt - 1)) & 1) != 0);
      end
      5'd12: begin
        r = ua >> amt;
        c = (amt == 0) ? 1'b0 : (((ua >> (amt - 1)) & 1) != 0);
      end
      5'd13: begin r = ((ua << 1) | (ua >> 7)) & 255; c = (ua >= 128); end
      5'd14: begin r = (ua >> 1) | ((ua & 1) << 7); c = ((ua & 1) != 0); end
      5'd15: begin
        t = ua + ub; r = t & 255; c = (t > 255);
        t = sa + sb; v = (t > 127) || (t < -128);
      end
      5'd16: begin
        r = (ua - ub) & 255; c = (ua < ub);
        t = sa - sb; v = (t > 127) || (t < -128);
      end
      default: begin legal = 1'b0; e = 1'b1; end
    endcase
    if (legal) begin
      r8 = 8'(r);
      f  = {~^r8, v, c, r8[7], (r8 == 8'h00)};
    end else begin
      r8 = prev_res;
      f  = prev_fl;
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [4:0] f, output logic e,
                        output int lat, output logic busy_acc, output logic busy_done);
    bus.iStart = 1'b1; bus.iALU_Sel = op; bus.iA = a; bus.iB = b;
    @(posedge clk); #1;
    // scramble inputs after capture; they must not matter
    bus.iStart = 1'b0;
    bus.iALU_Sel = 5'($urandom); bus.iA = 8'($urandom); bus.iB = 8'($urandom);
    lat = 1;
    busy_acc = bus.oBusy;
    while (!bus.oDone && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.oRESALU; f = bus.oBanderas; e = bus.oErr; busy_done = bus.oBusy;
  endtask

  task automatic check_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic [4:0] ef,
                          input logic ee);
    logic [7:0] r; logic [4:0] f; logic e, ba, bd; int lat, elat;
    run_op(op, a, b, r, f, e, lat, ba, bd);
    elat = (op == 5'd0 || op == 5'd1 || op == 5'd17) ? 10 : 2;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy_after_accept"}, 32'(ba), 32'd1);
    chk({tag, " busy_at_done"}, 32'(bd), 32'd0);
    chk({tag, " result"}, 32'(r), 32'(er));
    chk({tag, " flags"}, 32'(f), 32'(ef));
    chk({tag, " err"}, 32'(e), 32'(ee));
    prev_res = er;
    prev_fl  = ef;
  endtask

  initial begin
    logic [7:0] er; logic [4:0] ef; logic ee;
    logic [4:0] op; logic [7:0] a, b;
    int lat, extra;

    //          op     A      B      res    {P,V,C,S,Z} err
    vt[0]  = '{5'h0F, 8'hFF, 8'h01, 8'h00, 5'b10101, 1'b0}; // ADD
    vt[1]  = '{5'h10, 8'h80, 8'h01, 8'h7F, 5'b01000, 1'b0}; // SUB
    vt[2]  = '{5'h10, 8'h01, 8'h02, 8'hFF, 5'b10110, 1'b0}; // SUB
    vt[3]  = '{5'h00, 8'd12, 8'd11, 8'h84, 5'b10010, 1'b0}; // MUL
    vt[4]  = '{5'h00, 8'h10, 8'h20, 8'h00, 5'b11101, 1'b0}; // MUL overflow
    vt[5]  = '{5'h01, 8'd200, 8'd7, 8'h1C, 5'b00000, 1'b0}; // DIV
    vt[6]  = '{5'h11, 8'd200, 8'd7, 8'h04, 5'b00000, 1'b0}; // remainder
    vt[7]  = '{5'h01, 8'd5, 8'd0, 8'hFF, 5'b10010, 1'b1};   // DIV by 0
    vt[8]  = '{5'h11, 8'h37, 8'd0, 8'h37, 5'b00000, 1'b1};  // remainder by 0
    vt[9]  = '{5'h0A, 8'h90, 8'd2, 8'hE4, 5'b10010, 1'b0};  // ASR
    vt[10] = '{5'h0A, 8'h90, 8'd9, 8'hFF, 5'b10110, 1'b0};  // ASR >= WIDTH
    vt[11] = '{5'h0B, 8'h81, 8'd1, 8'h02, 5'b00100, 1'b0};  // LSL
    vt[12] = '{5'h0E, 8'h01, 8'd0, 8'h80, 5'b00110, 1'b0};  // ROR
    vt[13] = '{5'h1F, 8'h12, 8'h34, 8'h80, 5'b00110, 1'b1}; // illegal: hold
    vt[14] = '{5'h09, 8'h40, 8'd1, 8'h80, 5'b01010, 1'b0};  // ASL overflow
    vt[15] = '{5'h02, 8'h7F, 8'd0, 8'h80, 5'b01010, 1'b0};  // INC overflow
    vt[16] = '{5'h03, 8'h00, 8'd0, 8'hFF, 5'b10110, 1'b0};  // DEC wrap
    vt[17] = '{5'h08, 8'h80, 8'd0, 8'h80, 5'b01010, 1'b0};  // NEG min

    bus.iStart = 1'b0; bus.iALU_Sel = '0; bus.iA = '0; bus.iB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.oBusy), 32'd0);
    chk("reset done", 32'(bus.oDone), 32'd0);
    chk("reset err", 32'(bus.oErr), 32'd0);
    chk("reset result", 32'(bus.oRESALU), 32'd0);
    chk("reset flags", 32'(bus.oBanderas), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      check_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].fl, vt[i].err);

    // iStart pulsed while a MUL is iterating must be ignored
    bus.iStart = 1'b1; bus.iALU_Sel = 5'h00; bus.iA = 8'd12; bus.iB = 8'd11;
    @(posedge clk); #1;
    bus.iStart = 1'b0; lat = 1;
    @(posedge clk); #1; lat++;
    bus.iStart = 1'b1; bus.iALU_Sel = 5'h0F; bus.iA = 8'h01; bus.iB = 8'h01;
    @(posedge clk); #1; lat++;
    bus.iStart = 1'b0;
    while (!bus.oDone && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("midmul latency", 32'(lat), 32'd10);
    chk("midmul result", 32'(bus.oRESALU), 32'h84);
    chk("midmul flags", 32'(bus.oBanderas), 32'(5'b10010));
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.oDone || bus.oBusy) extra++; end
    chk("midmul no_second_op", 32'(extra), 32'd0);

    // reset on the 4th ITER cycle aborts the MUL without oDone
    bus.iStart = 1'b1; bus.iALU_Sel = 5'h00; bus.iA = 8'd9; bus.iB = 8'd7;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(bus.oBusy), 32'd0);
    chk("abort done", 32'(bus.oDone), 32'd0);
    chk("abort result", 32'(bus.oRESALU), 32'd0);
    chk("abort flags", 32'(bus.oBanderas), 32'd0);
    rst = 1'b0;
    prev_res = 8'h00; prev_fl = 5'h00;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.oDone) extra++; end
    chk("abort no_done", 32'(extra), 32'd0);
    check_op("post_abort add", 5'h0F, 8'd3, 8'd4, 8'h07, 5'b00000, 1'b0);

    // randomized operations against the reference model
    for (int i = 0; i < 250; i++) begin
      op = 5'($urandom_range(0, 20));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 15) == 0) b = 8'h00;
      model(op, a, b, er, ef, ee);
      check_op($sformatf("rnd%0d op%0d a%0h b%0h", i, op, a, b), op, a, b, er, ef, ee);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
